// File: rtl/lcd_readback.sv
// lcd_readback
//   Reads the 32 characters of a 2x16 HD44780 panel back over its 4-bit bus
//   and presents them as a packed ASCII string. The pins are shared with the
//   LCD writer and are only touched after bus_gnt is seen.
//
//   Optional feature macro: LCD_RB_TIMEOUT_EN (bounded busy-flag polling).
//
// Parameters
//   CLK_DIV   clk cycles per bus phase (SETUP / PULSE / HOLD), >= 1
//   BF_LIMIT  busy polls before giving up (only with LCD_RB_TIMEOUT_EN)
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   start            one-cycle request for a readback (accepted in IDLE only)
//   busy             high from accepted start until done
//   done             one-cycle end-of-readback pulse
//   err              result of the last readback, valid with done
//   str_out          char 0 in [255:248] ... char 31 in [7:0]
//   bus_req/bus_gnt  pin ownership handshake with the writer
//   lcd_rs/rw/e      LCD control lines
//   lcd_dat_out/oe   nibble driven on writes and its tri-state enable
//   lcd_dat_in       nibble read from the panel
//
// Handshake: bus_req rises with busy and is held until done. The pins are
// driven only while bus_gnt is high; if bus_gnt falls mid-transfer the current
// bus phase completes, the pins go quiet and the readback ends with err=1.
module lcd_readback #(
  parameter int CLK_DIV  = 4,
  parameter int BF_LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [255:0] str_out,
  output logic         bus_req,
  input  logic         bus_gnt,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [3:0]   lcd_dat_out,
  output logic         lcd_dat_oe,
  input  logic [3:0]   lcd_dat_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BF1, S_ADDR, S_BF2, S_RD, S_FIN, S_ABORT
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_PULSE, PH_HOLD
  } phase_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  phase_t           phase;
  logic [DIV_W-1:0] div_cnt;
  logic             nib;        // 0: high nibble, 1: low nibble
  logic [4:0]       char_idx;   // bit 4 doubles as the current line
  logic [3:0]       hi_nib;
  logic [255:0]     str_q;
  logic             err_q;
  logic             gnt_q;
  logic             lost_q;

  logic in_byte, phase_end, byte_end, lost, bf_busy, bf_timeout, start_acc;

  assign in_byte   = (state == S_BF1) || (state == S_ADDR) ||
                     (state == S_BF2) || (state == S_RD);
  assign phase_end = (div_cnt == DIV_LAST);
  assign byte_end  = phase_end && (phase == PH_HOLD) && nib;
  // Grant loss is acted on at the end of the phase in progress.
  assign lost      = lost_q || !bus_gnt;
  assign bf_busy   = hi_nib[3];
  assign start_acc = (state == S_IDLE) && start;

`ifdef LCD_RB_TIMEOUT_EN
  localparam int PC_W = $clog2(BF_LIMIT + 1);
  logic [PC_W-1:0] poll_cnt;

  // Counts consecutive busy answers inside one BF state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poll_cnt <= '0;
    end else if (start_acc) begin
      poll_cnt <= '0;
    end else if (byte_end && ((state == S_BF1) || (state == S_BF2))) begin
      if (bf_busy) poll_cnt <= poll_cnt + 1'b1;
      else         poll_cnt <= '0;
    end
  end

  assign bf_timeout = (poll_cnt == PC_W'(BF_LIMIT - 1));
`else
  assign bf_timeout = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      // gnt_q delays the first SETUP to the edge after the grant is sampled.
      S_REQ:  if (gnt_q) state_nxt = S_BF1;
      S_BF1, S_ADDR, S_BF2, S_RD: begin
        if (phase_end && lost) begin
          state_nxt = S_ABORT;
        end else if (byte_end) begin
          case (state)
            S_BF1: begin
              if (bf_busy && bf_timeout) state_nxt = S_ABORT;
              else if (!bf_busy)         state_nxt = S_ADDR;
            end
            S_ADDR: state_nxt = S_BF2;
            S_BF2: begin
              if (bf_busy && bf_timeout) state_nxt = S_ABORT;
              else if (!bf_busy)         state_nxt = S_RD;
            end
            S_RD: begin
              if (char_idx[3:0] == 4'hF)
                state_nxt = char_idx[4] ? S_FIN : S_BF1;
            end
            default: state_nxt = state;
          endcase
        end
      end
      S_FIN, S_ABORT: state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= PH_SETUP;
      div_cnt  <= '0;
      nib      <= 1'b0;
      char_idx <= '0;
      hi_nib   <= '0;
      str_q    <= {32{8'h20}};
      err_q    <= 1'b0;
      gnt_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_q <= bus_gnt;

      if (start_acc) begin
        phase    <= PH_SETUP;
        div_cnt  <= '0;
        nib      <= 1'b0;
        char_idx <= '0;
        err_q    <= 1'b0;
        lost_q   <= 1'b0;
      end else if (in_byte) begin
        if (!bus_gnt) lost_q <= 1'b1;
        if (phase_end) begin
          div_cnt <= '0;
          case (phase)
            PH_SETUP: phase <= PH_PULSE;
            PH_PULSE: begin
              phase <= PH_HOLD;
              if (!nib) begin
                hi_nib <= lcd_dat_in;
              end else if ((state == S_RD) && !lost) begin
                for (int i = 0; i < 32; i++)
                  if (char_idx == 5'(i)) str_q[(31 - i) * 8 +: 8] <= {hi_nib, lcd_dat_in};
              end
            end
            default: begin
              phase <= PH_SETUP;
              nib   <= ~nib;
              if (nib && (state == S_RD)) char_idx <= char_idx + 1'b1;
            end
          endcase
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      if (state_nxt == S_ABORT) err_q <= 1'b1;
    end
  end

  // Outputs are decoded from registered state only.
  assign busy        = (state != S_IDLE) && (state != S_FIN) && (state != S_ABORT);
  assign done        = (state == S_FIN) || (state == S_ABORT);
  assign err         = err_q;
  assign bus_req     = busy;
  assign str_out     = str_q;
  assign lcd_e       = in_byte && (phase == PH_PULSE);
  assign lcd_rs      = (state == S_RD);
  assign lcd_rw      = (state != S_ADDR);
  assign lcd_dat_oe  = (state == S_ADDR);
  // Set-DDRAM-address command: 0x80 for line 0, 0xC0 for line 1.
  assign lcd_dat_out = (state != S_ADDR) ? 4'h0 :
                       nib               ? 4'h0 :
                       char_idx[4]       ? 4'hC : 4'h8;

endmodule

// File: tb/tb_lcd_readback.sv
// Bench for lcd_readback: a small HD44780 model answers on the pins; directed
// steps cover reset, plain readback, busy polling, grant loss, reset mid-op
// and the busy-flag timeout (with or without LCD_RB_TIMEOUT_EN).
module tb_lcd_readback;

  localparam int CLK_DIV  = 4;
  localparam int BF_LIMIT = 255;
  localparam logic [255:0] SPACES = {32{8'h20}};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, bus_gnt;
  logic         busy, done, err, bus_req, lcd_rs, lcd_rw, lcd_e, lcd_dat_oe;
  logic [255:0] str_out;
  logic [3:0]   lcd_dat_out, lcd_dat_in;

  lcd_readback #(.CLK_DIV(CLK_DIV), .BF_LIMIT(BF_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err(err), .str_out(str_out), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_dat_out(lcd_dat_out), .lcd_dat_oe(lcd_dat_oe), .lcd_dat_in(lcd_dat_in)
  );

  int checks   = 0;
  int failures = 0;

  // LCD model, evaluated on the falling clk edge
  logic [7:0] ddram [0:127];
  logic       mdl_rst;
  int         cfg_bf_line1;
  logic       cfg_bf_always;
  logic [6:0] m_addr;
  logic       m_hi, m_e_prev, m_rs_l, m_rw_l, m_last_busy, m_busy_now;
  logic [7:0] m_cur, m_wr;
  int         m_bf_used, bf_bytes, rd_nibs;

  always @(negedge clk) begin
    if (mdl_rst) begin
      m_addr = '0; m_hi = 1'b1; m_e_prev = 1'b0; m_last_busy = 1'b0;
      m_bf_used = 0; bf_bytes = 0; rd_nibs = 0; lcd_dat_in = 4'h0;
      m_rs_l = 1'b0; m_rw_l = 1'b1; m_wr = '0; m_cur = '0;
    end else begin
      if (lcd_e && !m_e_prev) begin
        m_rs_l = lcd_rs; m_rw_l = lcd_rw;
        if (lcd_rs) rd_nibs++;
        if (lcd_rw) begin
          if (m_hi) begin
            m_busy_now = cfg_bf_always || ((m_addr == 7'h10) && (m_bf_used < cfg_bf_line1));
            m_cur = lcd_rs ? ddram[m_addr] : {m_busy_now, m_addr};
            if (!lcd_rs) begin bf_bytes++; m_last_busy = m_busy_now; end
          end
          lcd_dat_in = m_hi ? m_cur[7:4] : m_cur[3:0];
        end else begin
          if (m_hi) m_wr[7:4] = lcd_dat_out;
          else      m_wr[3:0] = lcd_dat_out;
        end
      end
      if (!lcd_e && m_e_prev) begin
        if (!m_hi) begin
          if (m_rs_l && m_rw_l)   m_addr = m_addr + 7'd1;
          if (!m_rs_l && !m_rw_l) m_addr = m_wr[6:0];
          if (!m_rs_l && m_rw_l && m_last_busy) m_bf_used++;
        end
        m_hi = !m_hi;
      end
      m_e_prev = lcd_e;
    end
  end

  // pin monitor: data enable cycles and rs/rw stability while E is high
  int   oe_cycles, rsrw_viol;
  logic mon_rs, mon_rw;
  always @(negedge clk) begin
    if (mdl_rst) begin
      oe_cycles = 0; rsrw_viol = 0; mon_rs = 1'b0; mon_rw = 1'b1;
    end else begin
      if (lcd_dat_oe) oe_cycles++;
      if (lcd_e && ((lcd_rs !== mon_rs) || (lcd_rw !== mon_rw))) rsrw_viol++;
      mon_rs = lcd_rs; mon_rw = lcd_rw;
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},    256'(busy), 256'(0));
    chk({pfx, "_done"},    256'(done), 256'(0));
    chk({pfx, "_err"},     256'(err), 256'(0));
    chk({pfx, "_str"},     str_out, SPACES);
    chk({pfx, "_req"},     256'(bus_req), 256'(0));
    chk({pfx, "_e"},       256'(lcd_e), 256'(0));
    chk({pfx, "_rs"},      256'(lcd_rs), 256'(0));
    chk({pfx, "_rw"},      256'(lcd_rw), 256'(1));
    chk({pfx, "_dat_out"}, 256'(lcd_dat_out), 256'(0));
    chk({pfx, "_oe"},      256'(lcd_dat_oe), 256'(0));
  endtask

  task automatic model_reset();
    mdl_rst = 1'b1;
    @(negedge clk);
    #1 mdl_rst = 1'b0;
  endtask

  task automatic dut_reset();
    @(negedge clk);
    rst_n = 1'b0; bus_gnt = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Pulses start, grants 2 cycles after the request, returns edges from the
  // grant-sampling edge until done is seen (-1 if the bound expires).
  task automatic run_read(input string pfx, input int bound, output int cyc);
    int n;
    cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({pfx, "_busy_after_start"}, 256'(busy), 256'(1));
    chk({pfx, "_req_after_start"},  256'(bus_req), 256'(1));
    repeat (2) @(negedge clk);
    bus_gnt = 1'b1;
    @(posedge clk);
    n = 0;
    while ((cyc < 0) && (n < bound)) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) cyc = n;
    end
  endtask

  logic [255:0] exp_str, exp_gl;
  int           cyc, lat, dcnt;

  initial begin
    exp_str = "1234567887654321FD06|E03|M07|W0A";
    exp_gl  = {40'h3132333435, {27{8'h20}}};
    for (int i = 0; i < 128; i++) ddram[i] = 8'h2A;
    for (int k = 0; k < 16; k++) begin
      ddram[k]        = exp_str[255 - 8 * k -: 8];
      ddram[8'h40 + k] = exp_str[127 - 8 * k -: 8];
    end
    cfg_bf_line1 = 0; cfg_bf_always = 1'b0;
    mdl_rst = 1'b1;
    start = 1'b0; bus_gnt = 1'b0; rst_n = 1'b0;

    // step 1: reset values after the first edge with rst_n low
    @(posedge clk); #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    model_reset();

    // step 2: basic readback
    run_read("basic", 3000, cyc);
    chk("basic_latency",  256'(cyc), 256'(913));
    chk("basic_err",      256'(err), 256'(0));
    chk("basic_busy_low", 256'(busy), 256'(0));
    chk("basic_req_low",  256'(bus_req), 256'(0));
    chk("basic_str",      str_out, exp_str);
    chk("basic_bf_bytes", 256'(bf_bytes), 256'(4));
    chk("basic_oe_cycles", 256'(oe_cycles), 256'(2 * 6 * CLK_DIV));
    chk("basic_rsrw_stable", 256'(rsrw_viol), 256'(0));
    @(posedge clk); #1;
    chk("basic_done_one_cycle", 256'(done), 256'(0));
    bus_gnt = 1'b0;

    // step 3: three busy answers before line 1 address
    dut_reset();
    cfg_bf_line1 = 3;
    run_read("bfpoll", 3000, cyc);
    chk("bfpoll_latency",  256'(cyc), 256'(913 + 72));
    chk("bfpoll_bf_bytes", 256'(bf_bytes), 256'(7));
    chk("bfpoll_err",      256'(err), 256'(0));
    chk("bfpoll_str",      str_out, exp_str);
    bus_gnt = 1'b0;
    cfg_bf_line1 = 0;

    // step 4: grant lost during the char 5 high-nibble PULSE
    dut_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    bus_gnt = 1'b1;
    dcnt = 0;
    while ((rd_nibs < 11) && (dcnt < 2000)) begin
      @(posedge clk); #2; dcnt++;
    end
    chk("gl_reached_char5", 256'(rd_nibs), 256'(11));
    chk("gl_e_high_at_drop", 256'(lcd_e), 256'(1));
    bus_gnt = 1'b0;
    lat = 0;
    while (((lcd_e !== 1'b0) || (lcd_dat_oe !== 1'b0)) && (lat < 20)) begin
      @(posedge clk); #1; lat++;
    end
    chk("gl_quiet_in_time", 256'(lat <= CLK_DIV + 1), 256'(1));
    dcnt = 0;
    while ((done !== 1'b1) && (dcnt < 20)) begin
      @(posedge clk); #1; dcnt++;
    end
    chk("gl_done", 256'(done), 256'(1));
    chk("gl_err",  256'(err), 256'(1));
    chk("gl_req",  256'(bus_req), 256'(0));
    chk("gl_str",  str_out, exp_gl);
    @(posedge clk); #1;
    chk("gl_done_one_cycle", 256'(done), 256'(0));
    chk("gl_err_held",       256'(err), 256'(1));

    // step 5: reset pulse at char 20, then a fresh readback
    dut_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    bus_gnt = 1'b1;
    dcnt = 0;
    while ((rd_nibs < 41) && (dcnt < 3000)) begin
      @(posedge clk); #2; dcnt++;
    end
    chk("midrst_reached_char20", 256'(rd_nibs), 256'(41));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    rst_n = 1'b1; bus_gnt = 1'b0;
    model_reset();
    run_read("fresh", 3000, cyc);
    chk("fresh_latency", 256'(cyc), 256'(913));
    chk("fresh_err",     256'(err), 256'(0));
    chk("fresh_str",     str_out, exp_str);
    bus_gnt = 1'b0;

    // step 6: panel stuck busy
    dut_reset();
    cfg_bf_always = 1'b1;
`ifdef LCD_RB_TIMEOUT_EN
    run_read("tmo", 8000, cyc);
    chk("tmo_latency",  256'(cyc), 256'(1 + BF_LIMIT * 6 * CLK_DIV));
    chk("tmo_err",      256'(err), 256'(1));
    chk("tmo_req",      256'(bus_req), 256'(0));
    chk("tmo_bf_bytes", 256'(bf_bytes), 256'(BF_LIMIT));
`else
    run_read("tmo", 10000, cyc);
    chk("tmo_no_done",    256'(cyc), 256'(-1));
    chk("tmo_still_busy", 256'(busy), 256'(1));
    chk("tmo_still_req",  256'(bus_req), 256'(1));
`endif
    cfg_bf_always = 1'b0;
    dut_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
